l2_line_arbiter: RTL and testbench
==================================

Name: l2_line_arbiter

Overview:
- Downstream neighbour of the L1 caches: arbitrates 256-bit line transfers from the I-cache and the multiport nonblocking D-cache onto the single L2 line port.
- The D-cache side carries both read misses (MSHR refills) and writebacks (replacement-buffer drains). The I-cache side issues line reads only.
- Both requests are latched at grant, so the L1 may change its address or data after the grant without corrupting the transfer in flight.

Parameters:
- ADDR_W, 16, byte address width (line-aligned; bits [4:0] forwarded as given).
- LINE_W, 256, line width in bits (one lc3b_32bytes).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp
- i_pmem_address  in  ADDR_W  I-cache line address
- i_pmem_resp  out  1  one-cycle completion pulse to the I-cache
- i_pmem_rdata  out  LINE_W  line returned to the I-cache
- d_pmem_read  in  1  D-cache read request (MSHR refill), held until d_pmem_resp
- d_pmem_write  in  1  D-cache write request (RPB drain), held until d_pmem_resp
- d_pmem_address  in  ADDR_W  D-cache line address
- d_pmem_wdata  in  LINE_W  D-cache writeback line
- d_pmem_resp  out  1  one-cycle completion pulse to the D-cache
- d_pmem_rdata  out  LINE_W  line returned to the D-cache
- l2_read  out  1  read strobe to L2, held until l2_resp
- l2_write  out  1  write strobe to L2, held until l2_resp
- l2_address  out  ADDR_W  latched request address
- l2_wdata  out  LINE_W  latched write line
- l2_resp  in  1  L2 completion pulse
- l2_rdata  in  LINE_W  L2 read line, valid in the l2_resp cycle

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- Reset:
  - state goes to IDLE.
  - All outputs are 0: strobes, resp pulses, address, wdata, both rdata registers.
  - The round-robin pointer, if compiled in, is cleared to favour D.
- IDLE:
  - If any request is pending, the arbiter grants it on the clock edge.
  - On grant it latches l2_address, l2_wdata (D writes only) and the op type.
  - It enters BUSY_x.
- BUSY_x:
  - l2_read or l2_write is driven from the latched op and held until l2_resp.
  - At most one of the two strobes is ever high.
- Request latency: a request first seen in IDLE at cycle 0 drives its strobe at cycle 1.
- On l2_resp in BUSY_x:
  - A read latches l2_rdata into the granted master's rdata register.
  - state moves to DONE_x.
  - The strobe drops in the same edge.
- DONE_x: x_pmem_resp is high for exactly one cycle, then state returns to IDLE.
  - The mandatory IDLE turnaround cycle stops a request that is still asserted during the resp cycle from being re-granted.
- End-to-end timing: l2_resp at cycle N gives x_pmem_resp at cycle N+1, with data already stable on x_pmem_rdata. The minimum request-to-resp time is L2 latency + 2.
- x_pmem_rdata holds its last value until the next completed read for that master.
- d_pmem_read and d_pmem_write both high is illegal. The write takes precedence, and a write is never dropped.
- l2_resp outside BUSY_x is ignored.
- Requests that arrive during BUSY or DONE wait; there is no queueing beyond the requester holding its line.
- Reset mid-transfer: immediate return to IDLE and the transaction is abandoned. L2 shares rst and is reset in the same cycle.

Optional Feature:
- Macro: L2_ARB_ROUND_ROBIN_EN
- Defined:
  - A 1-bit last_grant register; the loser of the last contended arbitration wins the next one.
  - Uncontended requests are granted immediately regardless of the pointer.
- Undefined:
  - Fixed priority: D-cache beats I-cache, because writebacks free RPB entries and refills free MSHR entries.
  - No pointer register exists.

Decomposition:
- lc3b_types gains:
  - lc3b_l2_arb_state enum (IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D).
  - lc3b_l2_op enum (L2_OP_READ, L2_OP_WRITE).
- Existing lc3b_word and lc3b_32bytes are used for the address and line types.
- One sub-module: l2_arb_grant, a purely combinational priority/round-robin selector taking the request vector and last_grant and producing a one-hot grant. It keeps the ifdef localized.

Test Plan:
- Single I read 0x1240; L2 responds 3 cycles after the strobe with line 0xA5 repeated → l2_read at cycle 1, l2_address=0x1240, i_pmem_resp at cycle 5, i_pmem_rdata = 0xA5 line, d_pmem_resp never asserts.
- Simultaneous I read 0x0020 and D write 0x4000 (wdata 0x5A.. line), macro off → D served first (l2_write, l2_wdata=0x5A..), then IDLE cycle, then I read 0x0020.
- Same contention repeated three times with macro on → grant order D, I, D, I, D, I.
- D changes d_pmem_address to 0xFFE0 the cycle after grant of 0x3000 → l2_address stays 0x3000 until l2_resp.
- rst asserted during BUSY_D with l2_write high → next cycle l2_write=0, state IDLE, no d_pmem_resp. A spurious l2_resp in IDLE produces no resp pulse.
- D read and write both high for 0x2000 → l2_write only, l2_read stays 0 throughout.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word/line containers plus the L2 line arbiter's
// state and operation encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [255:0] lc3b_32bytes;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } lc3b_l2_arb_state;

  typedef enum logic {
    L2_OP_READ,
    L2_OP_WRITE
  } lc3b_l2_op;

  localparam int L2_REQ_I = 0;
  localparam int L2_REQ_D = 1;

endpackage

// File: rtl/l2_arb_grant.sv
// Combinational I/D grant selector for the L2 line arbiter; L2_ARB_ROUND_ROBIN_EN
// switches from fixed D-over-I priority to alternating priority on contention.
module l2_arb_grant
  import lc3b_types::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef L2_ARB_ROUND_ROBIN_EN
  // last_grant set means D won the previous contest, so I is owed this one
  always_comb begin
    grant = req;
    if (req[L2_REQ_D] && req[L2_REQ_I]) begin
      grant = 2'b00;
      if (last_grant) begin
        grant[L2_REQ_I] = 1'b1;
      end else begin
        grant[L2_REQ_D] = 1'b1;
      end
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // D first: its writebacks and refills release RPB and MSHR entries
  always_comb begin
    grant = 2'b00;
    if (req[L2_REQ_D]) begin
      grant[L2_REQ_D] = 1'b1;
    end else if (req[L2_REQ_I]) begin
      grant[L2_REQ_I] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/l2_line_arbiter.sv
// Arbitrates I-cache line reads and D-cache reads/writebacks onto the single L2 line
// port. Optional round-robin arbitration is compiled in with L2_ARB_ROUND_ROBIN_EN.
module l2_line_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata
);

  lc3b_l2_arb_state  state_q, state_d;
  lc3b_l2_op         op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              l2_read_q, l2_read_d;
  logic              l2_write_q, l2_write_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       last_grant;

  assign req[L2_REQ_I] = i_pmem_read;
  assign req[L2_REQ_D] = d_pmem_read | d_pmem_write;

  l2_arb_grant u_grant (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

`ifdef L2_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // Only contested grants move the pointer; a lone requester never consumes a turn
  always_comb begin
    last_grant_d = last_grant_q;
    if ((state_q == IDLE) && req[L2_REQ_I] && req[L2_REQ_D]) begin
      last_grant_d = grant[L2_REQ_D];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    l2_read_d  = l2_read_q;
    l2_write_d = l2_write_q;
    i_resp_d   = 1'b0;
    d_resp_d   = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        // Address, data and op are captured here so the L1 is free to move on
        if (grant[L2_REQ_D]) begin
          state_d = BUSY_D;
          addr_d  = d_pmem_address;
          if (d_pmem_write) begin
            op_d       = L2_OP_WRITE;
            wdata_d    = d_pmem_wdata;
            l2_write_d = 1'b1;
            l2_read_d  = 1'b0;
          end else begin
            op_d       = L2_OP_READ;
            l2_write_d = 1'b0;
            l2_read_d  = 1'b1;
          end
        end else if (grant[L2_REQ_I]) begin
          state_d    = BUSY_I;
          addr_d     = i_pmem_address;
          op_d       = L2_OP_READ;
          l2_read_d  = 1'b1;
          l2_write_d = 1'b0;
        end
      end

      BUSY_I: begin
        if (l2_resp) begin
          state_d    = DONE_I;
          i_rdata_d  = l2_rdata;
          i_resp_d   = 1'b1;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end
      end

      BUSY_D: begin
        if (l2_resp) begin
          state_d = DONE_D;
          if (op_q == L2_OP_READ) begin
            d_rdata_d = l2_rdata;
          end
          d_resp_d   = 1'b1;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end
      end

      // Forced turnaround: the requester still holds its line during the resp cycle
      DONE_I, DONE_D: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= L2_OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      i_resp_q   <= 1'b0;
      d_resp_q   <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      l2_read_q  <= l2_read_d;
      l2_write_q <= l2_write_d;
      i_resp_q   <= i_resp_d;
      d_resp_q   <= d_resp_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign l2_read      = l2_read_q;
  assign l2_write     = l2_write_q;
  assign l2_address   = addr_q;
  assign l2_wdata     = wdata_q;
  assign i_pmem_resp  = i_resp_q;
  assign i_pmem_rdata = i_rdata_q;
  assign d_pmem_resp  = d_resp_q;
  assign d_pmem_rdata = d_rdata_q;

endmodule

// File: tb/tb_l2_line_arbiter.sv
// Self-checking bench for l2_line_arbiter: directed cases then random I/D traffic
// against a transaction-level model; honours L2_ARB_ROUND_ROBIN_EN when defined.
`timescale 1ns/1ps
module tb_l2_line_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic              i_pmem_resp;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic              d_pmem_resp;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_address;
  logic [LINE_W-1:0] l2_wdata;
  logic              l2_resp;
  logic [LINE_W-1:0] l2_rdata;

  l2_line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_resp    (i_pmem_resp),
    .i_pmem_rdata   (i_pmem_rdata),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_resp    (d_pmem_resp),
    .d_pmem_rdata   (d_pmem_rdata),
    .l2_read        (l2_read),
    .l2_write       (l2_write),
    .l2_address     (l2_address),
    .l2_wdata       (l2_wdata),
    .l2_resp        (l2_resp),
    .l2_rdata       (l2_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  addr;
    bit           isWrite;
    bit           both;
    logic [255:0] wdata;
    int           lat;
    logic [255:0] rdata;
  } txn_t;

  txn_t         qI[$];
  txn_t         qD[$];
  txn_t         curI;
  txn_t         curD;
  bit           pendI;
  bit           pendD;
  logic [255:0] lastRdI;
  logic [255:0] lastRdD;
  int           checks = 0;
  int           failures = 0;
`ifdef L2_ARB_ROUND_ROBIN_EN
  bit           favorI;
`endif

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives the L1 request lines from the bench's notion of outstanding requests
  task automatic applyStimulus();
    i_pmem_read    = pendI;
    i_pmem_address = curI.addr;
    d_pmem_write   = pendD && curD.isWrite;
    d_pmem_read    = pendD && (!curD.isWrite || curD.both);
    d_pmem_address = curD.addr;
    d_pmem_wdata   = curD.wdata;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    pendI = 1'b0;
    pendD = 1'b0;
    applyStimulus();
    l2_resp  = 1'b0;
    l2_rdata = '0;
    stepCycle();
    stepCycle();
    rst = 1'b0;
    lastRdI = '0;
    lastRdD = '0;
`ifdef L2_ARB_ROUND_ROBIN_EN
    favorI = 1'b0;
`endif
  endtask

  function automatic txn_t mkTxn(input logic [15:0] addr, input bit isWrite, input bit both,
                                 input logic [255:0] wdata, input int lat,
                                 input logic [255:0] rdata);
    txn_t t;
    t.addr = addr;
    t.isWrite = isWrite;
    t.both = both;
    t.wdata = wdata;
    t.lat = lat;
    t.rdata = rdata;
    return t;
  endfunction

  function automatic txn_t randTxn(input bit isD);
    txn_t t;
    int kind;
    t.addr = 16'($urandom());
    t.addr[15] = isD;
    kind = isD ? int'($urandom_range(2, 0)) : 0;
    t.isWrite = (kind != 0);
    t.both = (kind == 2);
    t.wdata = {8{$urandom()}};
    t.lat = int'($urandom_range(4, 0));
    t.rdata = {8{$urandom()}};
    return t;
  endfunction

  task automatic issueNext(input bit isD);
    if (isD) begin
      if (qD.size() > 0) begin
        curD = qD.pop_front();
        pendD = 1'b1;
      end else begin
        pendD = 1'b0;
      end
    end else begin
      if (qI.size() > 0) begin
        curI = qI.pop_front();
        pendI = 1'b1;
      end else begin
        pendI = 1'b0;
      end
    end
  endtask

  // Arbitration rule: returns 1 for D, 0 for I, applied to the requests pending in IDLE
  function automatic int pickWinner();
    if (pendI && pendD) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
      if (favorI) begin
        favorI = 1'b0;
        return 0;
      end
      favorI = 1'b1;
      return 1;
`else
      return 1;
`endif
    end
    return pendD ? 1 : 0;
  endfunction

  // Plays the L1 masters and the L2 slave until both request queues drain
  task automatic runScenario(input string name);
    txn_t t;
    int   expWin = 0;
    int   serveM = 0;
    int   cnt = 0;
    int   expStrobe = 0;
    bit   active = 0;
    bit   respNext = 0;
    bit   dropI = 0;
    bit   dropD = 0;
    bit   finished = 0;
    t = mkTxn('0, 0, 0, '0, 0, '0);
    issueNext(0);
    issueNext(1);
    applyStimulus();
    expWin = pickWinner();
    for (int cyc = 0; cyc < 400; cyc++) begin
      stepCycle();
      l2_resp = 1'b0;
      if (respNext) begin
        checkOutput({name, "_i_resp"}, i_pmem_resp, serveM == 0);
        checkOutput({name, "_d_resp"}, d_pmem_resp, serveM == 1);
        checkOutput({name, "_i_rdata"}, i_pmem_rdata, lastRdI);
        checkOutput({name, "_d_rdata"}, d_pmem_rdata, lastRdD);
        checkOutput({name, "_strobe_drop"}, {l2_read, l2_write}, 2'b00);
        respNext = 1'b0;
        active = 1'b0;
        if (serveM == 1) dropD = 1'b1;
        else dropI = 1'b1;
      end else begin
        checkOutput({name, "_no_resp"}, {i_pmem_resp, d_pmem_resp}, 2'b00);
        if (dropI || dropD) begin
          if (dropI) issueNext(0);
          if (dropD) issueNext(1);
          dropI = 1'b0;
          dropD = 1'b0;
          applyStimulus();
          if (pendI || pendD) begin
            expWin = pickWinner();
            expStrobe = cyc + 1;
          end
          checkOutput({name, "_turnaround"}, {l2_read, l2_write}, 2'b00);
        end else if (!active && (pendI || pendD) && cyc == expStrobe) begin
          serveM = expWin;
          t = (serveM == 1) ? curD : curI;
          checkOutput({name, "_grant_addr"}, l2_address, t.addr);
          checkOutput({name, "_grant_op"}, {l2_read, l2_write}, t.isWrite ? 2'b01 : 2'b10);
          if (t.isWrite) checkOutput({name, "_grant_wdata"}, l2_wdata, t.wdata);
          active = 1'b1;
          cnt = 0;
          if (serveM == 1) begin
            d_pmem_address = 16'hFFE0;
            d_pmem_wdata   = ~curD.wdata;
          end else begin
            i_pmem_address = 16'hFFE0;
          end
        end else if (active) begin
          checkOutput({name, "_hold_addr"}, l2_address, t.addr);
          checkOutput({name, "_hold_op"}, {l2_read, l2_write}, t.isWrite ? 2'b01 : 2'b10);
          if (t.isWrite) checkOutput({name, "_hold_wdata"}, l2_wdata, t.wdata);
        end else begin
          checkOutput({name, "_idle_strobe"}, {l2_read, l2_write}, 2'b00);
        end
        if (active) begin
          if (cnt == t.lat) begin
            l2_resp  = 1'b1;
            l2_rdata = t.rdata;
            if (!t.isWrite) begin
              if (serveM == 1) lastRdD = t.rdata;
              else lastRdI = t.rdata;
            end
            respNext = 1'b1;
          end
          cnt++;
        end
      end
      if (!pendI && !pendD && !active && !respNext && !dropI && !dropD) begin
        finished = 1'b1;
        break;
      end
    end
    checkOutput({name, "_complete"}, finished, 1'b1);
    if (!finished) begin
      qI.delete();
      qD.delete();
      applyReset();
    end
  endtask

  initial begin
    rst = 1'b1;
    l2_resp = 1'b0;
    l2_rdata = '0;
    curI = mkTxn('0, 0, 0, '0, 0, '0);
    curD = mkTxn('0, 0, 0, '0, 0, '0);
    applyReset();

    checkOutput("reset_strobes", {l2_read, l2_write}, 2'b00);
    checkOutput("reset_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
    checkOutput("reset_addr", l2_address, 16'h0000);
    checkOutput("reset_wdata", l2_wdata, '0);
    checkOutput("reset_i_rdata", i_pmem_rdata, '0);
    checkOutput("reset_d_rdata", d_pmem_rdata, '0);

    qI.push_back(mkTxn(16'h1240, 0, 0, '0, 3, {32{8'hA5}}));
    runScenario("single_i");

    qI.push_back(mkTxn(16'h0020, 0, 0, '0, 2, {8{$urandom()}}));
    qD.push_back(mkTxn(16'h4000, 1, 0, {32{8'h5A}}, 2, {8{$urandom()}}));
    runScenario("contend");

    applyReset();
    for (int k = 0; k < 3; k++) begin
      qI.push_back(randTxn(0));
      qD.push_back(mkTxn(16'h8000 + 16'(k * 32), 1, 0, {8{$urandom()}}, 1, {8{$urandom()}}));
    end
    runScenario("contend_x3");

    qD.push_back(mkTxn(16'h3000, 0, 0, '0, 3, {8{$urandom()}}));
    runScenario("addr_latch");

    qD.push_back(mkTxn(16'h2000, 1, 1, {8{$urandom()}}, 2, {8{$urandom()}}));
    runScenario("rd_wr_both");

    d_pmem_write   = 1'b1;
    d_pmem_address = 16'h5000;
    d_pmem_wdata   = {8{$urandom()}};
    stepCycle();
    checkOutput("midrst_busy", {l2_read, l2_write}, 2'b01);
    rst = 1'b1;
    d_pmem_write = 1'b0;
    stepCycle();
    checkOutput("midrst_strobe", {l2_read, l2_write}, 2'b00);
    checkOutput("midrst_addr", l2_address, 16'h0000);
    checkOutput("midrst_d_rdata", d_pmem_rdata, '0);
    checkOutput("midrst_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    rst = 1'b0;
    lastRdI = '0;
    lastRdD = '0;
`ifdef L2_ARB_ROUND_ROBIN_EN
    favorI = 1'b0;
`endif
    l2_resp = 1'b1;
    stepCycle();
    l2_resp = 1'b0;
    checkOutput("spurious_resp0", {i_pmem_resp, d_pmem_resp}, 2'b00);
    checkOutput("spurious_strobe", {l2_read, l2_write}, 2'b00);
    stepCycle();
    checkOutput("spurious_resp1", {i_pmem_resp, d_pmem_resp}, 2'b00);
    qI.push_back(mkTxn(16'h0100, 0, 0, '0, 1, {8{$urandom()}}));
    runScenario("after_rst");

    for (int r = 0; r < 25; r++) begin
      int nI;
      int nD;
      nI = int'($urandom_range(2, 0));
      nD = int'($urandom_range(2, 0));
      for (int k = 0; k < nI; k++) qI.push_back(randTxn(0));
      for (int k = 0; k < nD; k++) qD.push_back(randTxn(1));
      runScenario("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
